// File: rtl/uart_rx_if.sv
// Holding-register side of the UART receiver: received character, status flags,
// flow control and the consumer's read strobe.
interface uart_rx_if;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_overrun_err;
  logic       o_rts_n;
  logic       o_break;
  logic       i_rx_read;

  modport master (
    output o_rx_data,
    output o_rx_valid,
    output o_parity_err,
    output o_frame_err,
    output o_overrun_err,
    output o_rts_n,
    output o_break,
    input  i_rx_read
  );

  modport slave (
    input  o_rx_data,
    input  o_rx_valid,
    input  o_parity_err,
    input  o_frame_err,
    input  o_overrun_err,
    input  o_rts_n,
    input  o_break,
    output i_rx_read
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 5-8 data bits, optional parity, one stop bit, single-entry
// holding register with RTS flow control. Break detection when UART_RX_BREAK_DET_EN is defined.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_tick,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  input  logic       i_rx_serial,
  uart_rx_if.master  rx
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q;
  logic [7:0]    data_al;
  logic [1:0]    len_q;
  logic          par_en_q, par_type_q, par_err_q;
  logic          cfg_load, shift_en, par_sample, done;
  logic          hold_q, is_brk;

  logic [7:0]    data_q;
  logic          valid_q, rts_q, perr_q, ferr_q, ovr_q;
  logic          rd_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_rx_serial};
  end
  assign rxs = sync_q[1];

  // Data enters at bit 7; shifting down by (8 - len) right-aligns and zero-fills.
  always_comb begin
    data_al = shift_q >> (2'd3 - len_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    cfg_load   = 1'b0;
    shift_en   = 1'b0;
    par_sample = 1'b0;
    done       = 1'b0;
    if (rx_tick) begin
      case (state_q)
        IDLE: begin
          if (!hold_q && !rxs) begin
            state_d  = START;
            tcnt_d   = '0;
            cfg_load = 1'b1;
          end
        end
        START: begin
          if (tcnt_q == MID) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tcnt_q == LAST) begin
            tcnt_d   = '0;
            shift_en = 1'b1;
            bcnt_d   = bcnt_q + 3'd1;
            if (bcnt_q == {1'b1, len_q}) state_d = par_en_q ? PARITY : STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tcnt_q == LAST) begin
            tcnt_d     = '0;
            par_sample = 1'b1;
            state_d    = STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tcnt_q == LAST) begin
            tcnt_d  = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      if (cfg_load) begin
        len_q      <= i_num_bit_data;
        par_en_q   <= i_parity_en;
        par_type_q <= i_parity_type;
        par_err_q  <= 1'b0;
      end
      if (shift_en)   shift_q   <= {rxs, shift_q[7:1]};
      if (par_sample) par_err_q <= rxs ^ (^data_al) ^ par_type_q;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic          par_bit_q, brk_q;
  logic [TW-1:0] hcnt_q;

  assign is_brk = (data_al == '0) && (!par_en_q || !par_bit_q) && !rxs;

  // After a break, starts are ignored until the line has been high for a full bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
      hold_q    <= 1'b0;
      hcnt_q    <= '0;
    end else begin
      if (cfg_load)   par_bit_q <= 1'b0;
      if (par_sample) par_bit_q <= rxs;
      if (done && is_brk) begin
        brk_q  <= 1'b1;
        hold_q <= 1'b1;
        hcnt_q <= '0;
      end else if (hold_q && rx_tick) begin
        if (!rxs) begin
          hcnt_q <= '0;
        end else if (hcnt_q == LAST) begin
          hcnt_q <= '0;
          hold_q <= 1'b0;
          brk_q  <= 1'b0;
        end else begin
          hcnt_q <= hcnt_q + 1'b1;
        end
      end
    end
  end
  assign rx.o_break = brk_q;
`else
  assign hold_q     = 1'b0;
  assign is_brk     = 1'b0;
  assign rx.o_break = 1'b0;
`endif

  assign rd_ok = rx.i_rx_read && valid_q;

  // A read in the completion cycle frees the register first, so the new frame loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      rts_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (rd_ok) begin
        valid_q <= 1'b0;
        rts_q   <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (done && !is_brk) begin
        if (!valid_q || rd_ok) begin
          data_q  <= data_al;
          perr_q  <= par_err_q;
          ferr_q  <= ~rxs;
          valid_q <= 1'b1;
          rts_q   <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx.o_rx_data     = data_q;
  assign rx.o_rx_valid    = valid_q;
  assign rx.o_rts_n       = rts_q;
  assign rx.o_parity_err  = perr_q;
  assign rx.o_frame_err   = ferr_q;
  assign rx.o_overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected characters, a monitor checks
// each character as o_rx_valid rises and pops it with i_rx_read.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_tick;
  logic [1:0] i_num_bit_data;
  logic       i_parity_en;
  logic       i_parity_type;
  logic       i_rx_serial;
  logic [1:0] tdiv;

  int   checks;
  int   errors;
  exp_t sb[$];
  logic auto_read;
  logic read_req;

  uart_rx_if rx_bus ();

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tick        (rx_tick),
    .i_num_bit_data (i_num_bit_data),
    .i_parity_en    (i_parity_en),
    .i_parity_type  (i_parity_type),
    .i_rx_serial    (i_rx_serial),
    .rx             (rx_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rx_tick = 1'b0;
    tdiv    = 2'd0;
    forever begin
      @(negedge clk);
      tdiv    = tdiv + 2'd1;
      rx_tick = (tdiv == 2'd0);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_tick) k++;
    end
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] nb, input logic pe, input logic pt);
    i_num_bit_data = nb;
    i_parity_en    = pe;
    i_parity_type  = pt;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic pe,
                            input logic pbit, input logic stop_bit);
    wait_ticks(1);
    i_rx_serial = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < n; i++) begin
      i_rx_serial = d[i];
      wait_ticks(16);
    end
    if (pe) begin
      i_rx_serial = pbit;
      wait_ticks(16);
    end
    i_rx_serial = stop_bit;
    wait_ticks(16);
    i_rx_serial = 1'b1;
    wait_ticks(20);
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    rx_bus.i_rx_read = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_bus.o_rx_valid && !prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char actual=%02h required=none", rx_bus.o_rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", rx_bus.o_rx_data, e.d);
          check("parity_err", {7'd0, rx_bus.o_parity_err}, {7'd0, e.pe});
          check("frame_err", {7'd0, rx_bus.o_frame_err}, {7'd0, e.fe});
          check("overrun_at_load", {7'd0, rx_bus.o_overrun_err}, 8'd0);
          check("rts_n_full", {7'd0, rx_bus.o_rts_n}, 8'd1);
        end
      end
      prev = rx_bus.o_rx_valid;
      rx_bus.i_rx_read = rx_bus.o_rx_valid && (auto_read || read_req);
    end
  end

  initial begin : stim
    int budget;
    checks      = 0;
    errors      = 0;
    auto_read   = 1'b1;
    read_req    = 1'b0;
    rst_n       = 1'b0;
    i_rx_serial = 1'b1;
    set_cfg(2'b11, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", rx_bus.o_rx_data, 8'h00);
    check("rst_valid", {7'd0, rx_bus.o_rx_valid}, 8'd0);
    check("rst_errs", {5'd0, rx_bus.o_parity_err, rx_bus.o_frame_err, rx_bus.o_overrun_err}, 8'd0);
    check("rst_rts_n", {7'd0, rx_bus.o_rts_n}, 8'd0);
    check("rst_break", {7'd0, rx_bus.o_break}, 8'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("rts_n_after_read", {7'd0, rx_bus.o_rts_n}, 8'd0);
    check("valid_after_read", {7'd0, rx_bus.o_rx_valid}, 8'd0);

    // 7E1 0x55: four ones, correct even parity bit is 0
    set_cfg(2'b10, 1'b1, 1'b0);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
    push(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);

    // 5O1 0x1F: five ones, correct odd parity bit is 0
    set_cfg(2'b00, 1'b1, 1'b1);
    push(8'h1F, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    push(8'h1F, 1'b0, 1'b1);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b0);

    // glitch shorter than half a bit, then a clean 8N1 frame
    set_cfg(2'b11, 1'b0, 1'b0);
    wait_ticks(1);
    i_rx_serial = 1'b0;
    wait_ticks(3);
    i_rx_serial = 1'b1;
    wait_ticks(20);
    check("glitch_valid", {7'd0, rx_bus.o_rx_valid}, 8'd0);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);

    // overrun: hold 0x11 unread, 0x22 is dropped
    auto_read = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("ovr_data", rx_bus.o_rx_data, 8'h11);
    check("ovr_flag", {7'd0, rx_bus.o_overrun_err}, 8'd1);
    check("ovr_valid", {7'd0, rx_bus.o_rx_valid}, 8'd1);
    check("ovr_rts_n", {7'd0, rx_bus.o_rts_n}, 8'd1);
    read_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_req = 1'b0;
    check("read_valid", {7'd0, rx_bus.o_rx_valid}, 8'd0);
    check("read_ovr", {7'd0, rx_bus.o_overrun_err}, 8'd0);
    check("read_rts_n", {7'd0, rx_bus.o_rts_n}, 8'd0);
    auto_read = 1'b1;

    // reset in the middle of a frame
    wait_ticks(1);
    i_rx_serial = 1'b0;
    wait_ticks(40);
    i_rx_serial = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(20);
    check("midrst_valid", {7'd0, rx_bus.o_rx_valid}, 8'd0);
    check("midrst_errs", {5'd0, rx_bus.o_parity_err, rx_bus.o_frame_err, rx_bus.o_overrun_err}, 8'd0);

    // line low long enough for two back-to-back 8N1 frames
    wait_ticks(1);
    i_rx_serial = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    wait_ticks(306);
    check("brk_set", {7'd0, rx_bus.o_break}, 8'd1);
    check("brk_no_data", {7'd0, rx_bus.o_rx_valid}, 8'd0);
    i_rx_serial = 1'b1;
    wait_ticks(15);
    check("brk_hold", {7'd0, rx_bus.o_break}, 8'd1);
    wait_ticks(1);
    check("brk_clear", {7'd0, rx_bus.o_break}, 8'd0);
`else
    push(8'h00, 1'b0, 1'b1);
    push(8'h00, 1'b0, 1'b1);
    wait_ticks(306);
    i_rx_serial = 1'b1;
    wait_ticks(20);
    check("brk_tied", {7'd0, rx_bus.o_break}, 8'd0);
`endif
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);

    budget = 0;
    while (sb.size() != 0 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
